// File: rtl/decode_stage_ctrl_pkg.sv
// Shared decode types: decoded-instruction record, queue entry, stage state
// and the serializing-instruction classifier.
package C;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ILLEGAL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
    OP_STORE, OP_ALUI, OP_ALU, OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
    OP_MRET, OP_SRET, OP_WFI, OP_SFENCE_VMA, OP_CSR
  } op_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    op_t             op;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_valid;
    logic            rs1_valid;
    logic            rs2_valid;
    logic [XLEN-1:0] imm;
  } si_t;

  typedef enum logic {DS_RUN, DS_SERIALIZE} decode_state_t;

  typedef struct packed {
    si_t  si;
    logic fault;
  } dq_entry_t;

  function automatic logic is_serializing(input si_t si);
    case (si.op)
      OP_ECALL, OP_EBREAK, OP_MRET, OP_SRET, OP_WFI, OP_FENCE_I, OP_SFENCE_VMA:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

endpackage

// File: rtl/decode_queue.sv
// In-order FIFO of decoded entries; head is readable the cycle after push.
module decode_queue
  import C::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  dq_entry_t              din_i,
  output dq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  dq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Storage is never cleared, so an empty queue presents zeros
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/static_decoder.sv
// Purely combinational RV32I/privileged decoder; si_o.valid=0 flags an
// illegal encoding.
module static_decoder
  import C::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output si_t             si_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            wr;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign wr     = (instr_i[11:7] != 5'd0);
  assign imm_i  = sext32({{20{instr_i[31]}}, instr_i[31:20]});
  assign imm_s  = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
  assign imm_b  = sext32({{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0});
  assign imm_u  = sext32({instr_i[31:12], 12'h000});
  assign imm_j  = sext32({{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0});

  always_comb begin
    si_o        = '0;
    si_o.pc     = pc_i;
    si_o.funct3 = f3;
    si_o.rd     = instr_i[11:7];
    si_o.rs1    = instr_i[19:15];
    si_o.rs2    = instr_i[24:20];
    case (opcode)
      7'h37, 7'h17: begin
        si_o.valid    = 1'b1;
        si_o.op       = (opcode == 7'h37) ? OP_LUI : OP_AUIPC;
        si_o.rd_valid = wr;
        si_o.imm      = imm_u;
      end
      7'h6f: begin
        si_o.valid    = 1'b1;
        si_o.op       = OP_JAL;
        si_o.rd_valid = wr;
        si_o.imm      = imm_j;
      end
      7'h67: if (f3 == 3'd0) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_JALR;
        si_o.rd_valid  = wr;
        si_o.rs1_valid = 1'b1;
        si_o.imm       = imm_i;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_BRANCH;
        si_o.rs1_valid = 1'b1;
        si_o.rs2_valid = 1'b1;
        si_o.imm       = imm_b;
      end
      7'h03: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_LOAD;
        si_o.rd_valid  = wr;
        si_o.rs1_valid = 1'b1;
        si_o.imm       = imm_i;
      end
      7'h23: if (f3 <= 3'd2) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_STORE;
        si_o.rs1_valid = 1'b1;
        si_o.rs2_valid = 1'b1;
        si_o.imm       = imm_s;
      end
      7'h13: if ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_ALUI;
        si_o.rd_valid  = wr;
        si_o.rs1_valid = 1'b1;
        si_o.imm       = imm_i;
      end
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        si_o.valid     = 1'b1;
        si_o.op        = OP_ALU;
        si_o.rd_valid  = wr;
        si_o.rs1_valid = 1'b1;
        si_o.rs2_valid = 1'b1;
      end
      7'h0f: if (f3 <= 3'd1) begin
        si_o.valid = 1'b1;
        si_o.op    = (f3 == 3'd0) ? OP_FENCE : OP_FENCE_I;
      end
      7'h73: begin
        if (f3 == 3'd0) begin
          si_o.valid = 1'b1;
          case (instr_i)
            32'h0000_0073: si_o.op = OP_ECALL;
            32'h0010_0073: si_o.op = OP_EBREAK;
            32'h3020_0073: si_o.op = OP_MRET;
            32'h1020_0073: si_o.op = OP_SRET;
            32'h1050_0073: si_o.op = OP_WFI;
            default: begin
              if (f7 == 7'b0001001 && !wr) begin
                si_o.op        = OP_SFENCE_VMA;
                si_o.rs1_valid = 1'b1;
                si_o.rs2_valid = 1'b1;
              end else begin
                si_o.valid = 1'b0;
              end
            end
          endcase
        end else if (f3 != 3'd4) begin
          // CSR address travels in imm; the immediate forms carry uimm in rs1
          si_o.valid     = 1'b1;
          si_o.op        = OP_CSR;
          si_o.rd_valid  = wr;
          si_o.rs1_valid = !f3[2];
          si_o.imm       = XLEN'(instr_i[31:20]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode stage: decodes fetch words, queues them for dispatch and blocks
// intake behind serializing instructions. DECODE_STAGE_STATS_EN adds counters.
module decode_stage_ctrl
  import C::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [31:0]     fetch_data_i,
  input  logic            fetch_fault_i,
  output logic            si_valid_o,
  input  logic            si_ready_i,
  output si_t             si_o,
  output logic            si_fault_o,
  input  logic            flush_i,
  input  logic            resume_i,
  output logic            busy_o
`ifdef DECODE_STAGE_STATS_EN
  ,
  output logic [63:0]     stat_decoded_o,
  output logic [63:0]     stat_illegal_o,
  output logic [63:0]     stat_stall_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  decode_state_t state_q, state_d;
  si_t           dec_si;
  dq_entry_t     entry_in, head;
  logic [CW-1:0] count;
  logic          push, pop, serializing;

  static_decoder u_dec (
    .pc_i    (fetch_pc_i),
    .instr_i (fetch_data_i),
    .si_o    (dec_si)
  );

  assign fetch_ready_o = (state_q == DS_RUN) && (count < CW'(DEPTH)) && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign si_valid_o    = (count != '0);
  assign pop           = si_valid_o && si_ready_i && !flush_i;
  assign serializing   = is_serializing(dec_si) || !dec_si.valid || fetch_fault_i;

  always_comb begin
    entry_in.si    = dec_si;
    entry_in.fault = fetch_fault_i;
    if (fetch_fault_i) entry_in.si.valid = 1'b0;
  end

  decode_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (entry_in),
    .head_o  (head),
    .count_o (count)
  );

  // Flush outranks resume; intake only happens in RUN so no further overlap
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DS_RUN;
    end else if (state_q == DS_SERIALIZE) begin
      if (resume_i) state_d = DS_RUN;
    end else if (push && serializing) begin
      state_d = DS_SERIALIZE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DS_RUN;
    else       state_q <= state_d;
  end

  assign si_o       = head.si;
  assign si_fault_o = head.fault;
  assign busy_o     = (count != '0) || (state_q != DS_RUN);

`ifdef DECODE_STAGE_STATS_EN
  logic [63:0] stat_decoded_q, stat_decoded_d;
  logic [63:0] stat_illegal_q, stat_illegal_d;
  logic [63:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_decoded_d = stat_decoded_q + 64'(push);
    stat_illegal_d = stat_illegal_q + 64'(push && !dec_si.valid && !fetch_fault_i);
    stat_stall_d   = stat_stall_q + 64'(fetch_valid_i && !fetch_ready_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_decoded_q <= '0;
      stat_illegal_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_illegal_q <= stat_illegal_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_decoded_o = stat_decoded_q;
  assign stat_illegal_o = stat_illegal_q;
  assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_decode_stage_ctrl;
  import C::*;

  localparam int DEPTH = 2;
  localparam int K_ADDI = 0, K_LUI = 1, K_ADD = 2, K_MRET = 3, K_ECALL = 4, K_WFI = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, fetch_valid_i = 1'b0, fetch_fault_i = 1'b0;
  logic        si_ready_i = 1'b0, flush_i = 1'b0, resume_i = 1'b0;
  logic [31:0] fetch_pc_i = '0, fetch_data_i = '0;
  logic        fetch_ready_o, si_valid_o, si_fault_o, busy_o;
  si_t         si_o;
`ifdef DECODE_STAGE_STATS_EN
  logic [63:0] stat_decoded_o, stat_illegal_o, stat_stall_o;
  longint unsigned m_dec = 0, m_ill = 0, m_stall = 0;
`endif

  always #5 clk = ~clk;

  decode_stage_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_data_i  (fetch_data_i),
    .fetch_fault_i (fetch_fault_i),
    .si_valid_o    (si_valid_o),
    .si_ready_i    (si_ready_i),
    .si_o          (si_o),
    .si_fault_o    (si_fault_o),
    .flush_i       (flush_i),
    .resume_i      (resume_i),
    .busy_o        (busy_o)
`ifdef DECODE_STAGE_STATS_EN
    ,
    .stat_decoded_o(stat_decoded_o),
    .stat_illegal_o(stat_illegal_o),
    .stat_stall_o  (stat_stall_o)
`endif
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        fault;
    logic        valid;
    logic        ser;
    logic        chk;
    logic        chk_imm;
    logic        rs1v;
    logic [4:0]  rd;
    logic [31:0] imm;
  } item_t;

  item_t q[$];
  logic  ser_m = 1'b0;
  logic  just_reset = 1'b0;
  int    n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Builds an encoding together with what the decoder must report for it
  function automatic item_t mk_item(input int kind, input logic [31:0] pc, input logic fault,
                                    input logic [4:0] rd, input logic [4:0] rs, input logic [31:0] a);
    item_t it = '{default: '0};
    it.pc    = pc;
    it.fault = fault;
    it.rd    = rd;
    case (kind)
      K_ADDI: begin
        it.word = {a[11:0], rs, 3'b000, rd, 7'h13};
        it.imm  = {{20{a[11]}}, a[11:0]};
        it.chk = 1'b1; it.chk_imm = 1'b1; it.rs1v = 1'b1;
      end
      K_LUI: begin
        it.word = {a[19:0], rd, 7'h37};
        it.imm  = {a[19:0], 12'h000};
        it.chk = 1'b1; it.chk_imm = 1'b1; it.rs1v = 1'b0;
      end
      K_ADD: begin
        it.word = {7'h00, a[4:0], rs, 3'b000, rd, 7'h33};
        it.chk = 1'b1; it.rs1v = 1'b1;
      end
      K_MRET:  it.word = 32'h3020_0073;
      K_ECALL: it.word = 32'h0000_0073;
      K_WFI:   it.word = 32'h1050_0073;
      default: it.word = 32'h0000_0000;
    endcase
    it.valid = !fault && (kind != K_ILL);
    it.ser   = fault || (kind >= K_MRET);
    return it;
  endfunction

  // One clock: drive inputs, compare outputs against the model, advance the model
  task automatic cycle(input logic fv, input item_t it, input logic rdy, input logic fl,
                       input logic res, input logic rs, output logic acc);
    logic exp_ready, deq;
    fetch_valid_i = fv;     fetch_pc_i = it.pc; fetch_data_i = it.word;
    fetch_fault_i = it.fault; si_ready_i = rdy; flush_i = fl;
    resume_i = res;         rst_i = rs;
    #1;
    exp_ready = !ser_m && (q.size() < DEPTH) && !fl;
    check_eq("fetch_ready", fetch_ready_o, exp_ready);
    check_eq("si_valid", si_valid_o, q.size() != 0);
    check_eq("busy", busy_o, (q.size() != 0) || ser_m);
    if (q.size() != 0) begin
      check_eq("head_pc", si_o.pc, q[0].pc);
      check_eq("head_valid", si_o.valid, q[0].valid);
      check_eq("head_fault", si_fault_o, q[0].fault);
      if (q[0].chk && !q[0].fault) begin
        check_eq("head_rd", si_o.rd, q[0].rd);
        check_eq("head_rd_valid", si_o.rd_valid, q[0].rd != 5'd0);
        check_eq("head_rs1_valid", si_o.rs1_valid, q[0].rs1v);
      end
      if (q[0].chk_imm && !q[0].fault) check_eq("head_imm", si_o.imm, q[0].imm);
    end else if (just_reset) begin
      check_eq("reset_si_zero", si_o == '0, 1'b1);
      check_eq("reset_si_fault", si_fault_o, 1'b0);
    end
`ifdef DECODE_STAGE_STATS_EN
    check_eq("stat_decoded", stat_decoded_o, m_dec);
    check_eq("stat_illegal", stat_illegal_o, m_ill);
    check_eq("stat_stall", stat_stall_o, m_stall);
`endif
    acc = fv && exp_ready && !rs;
    deq = (q.size() != 0) && rdy && !fl;
    just_reset = rs;
    if (rs) begin
      q.delete();
      ser_m = 1'b0;
`ifdef DECODE_STAGE_STATS_EN
      m_dec = 0; m_ill = 0; m_stall = 0;
`endif
    end else begin
`ifdef DECODE_STAGE_STATS_EN
      if (acc) m_dec++;
      if (acc && !it.valid && !it.fault) m_ill++;
      if (fv && !exp_ready) m_stall++;
`endif
      if (fl) begin
        q.delete();
        ser_m = 1'b0;
      end else begin
        if (deq) void'(q.pop_front());
        if (acc) begin
          q.push_back(it);
          if (it.ser) ser_m = 1'b1;
        end else if (ser_m && res) begin
          ser_m = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    item_t nop = mk_item(K_ADDI, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0);
    for (int i = 0; i < n; i++) cycle(1'b0, nop, rdy, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic hold(input int n, input item_t it, input logic rdy, input logic fl, input logic res);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b1, it, rdy, fl, res, 1'b0, acc);
  endtask

  task automatic feed(input item_t it, input logic rdy);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 20) begin
      cycle(1'b1, it, rdy, 1'b0, 1'b0, 1'b0, acc);
      n++;
    end
    if (!acc) check_eq("feed_timeout", 1'b0, 1'b1);
  endtask

  task automatic resume_pulse();
    logic acc;
    item_t nop = mk_item(K_ADDI, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0);
    cycle(1'b0, nop, 1'b1, 1'b0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic  acc, have, asserted, fv, rdy, fl, res, rs;
    item_t pend, nop;
    logic [31:0] pc;
    int    r, kind;

    nop = mk_item(K_ADDI, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    cycle(1'b0, nop, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, nop, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(1, 1'b1);

    // ADDI x1,x0,5 straight through
    feed(mk_item(K_ADDI, 32'h8000_0000, 1'b0, 5'd1, 5'd0, 32'd5), 1'b1);
    idle(2, 1'b1);

    // Three back-to-back ADDIs against a stalled consumer
    feed(mk_item(K_ADDI, 32'h8000_0000, 1'b0, 5'd2, 5'd0, 32'd1), 1'b0);
    feed(mk_item(K_ADDI, 32'h8000_0004, 1'b0, 5'd3, 5'd0, 32'd2), 1'b0);
    hold(2, mk_item(K_ADDI, 32'h8000_0008, 1'b0, 5'd4, 5'd0, 32'hfff), 1'b0, 1'b0, 1'b0);
    feed(mk_item(K_ADDI, 32'h8000_0008, 1'b0, 5'd4, 5'd0, 32'hfff), 1'b1);
    idle(3, 1'b1);

    // Illegal word serializes until resume
    feed(mk_item(K_ILL, 32'h8000_0100, 1'b0, 5'd0, 5'd0, 32'h0), 1'b1);
    hold(4, mk_item(K_ADDI, 32'h8000_0104, 1'b0, 5'd5, 5'd1, 32'h7), 1'b1, 1'b0, 1'b0);
    resume_pulse();
    feed(mk_item(K_ADDI, 32'h8000_0104, 1'b0, 5'd5, 5'd1, 32'h7), 1'b1);
    idle(2, 1'b1);

    // MRET blocks the following ADDI; then a faulting ADDI serializes too
    feed(mk_item(K_MRET, 32'h8000_0200, 1'b0, 5'd0, 5'd0, 32'h0), 1'b1);
    hold(3, mk_item(K_ADDI, 32'h8000_0204, 1'b0, 5'd6, 5'd0, 32'h10), 1'b1, 1'b0, 1'b0);
    resume_pulse();
    feed(mk_item(K_ADDI, 32'h8000_0204, 1'b1, 5'd6, 5'd0, 32'h10), 1'b1);
    hold(3, mk_item(K_LUI, 32'h8000_0208, 1'b0, 5'd7, 5'd0, 32'h12345), 1'b1, 1'b0, 1'b0);
    resume_pulse();
    idle(1, 1'b1);

    // Full and serialized, then flush with a word presented
    feed(mk_item(K_ADDI, 32'h8000_0300, 1'b0, 5'd8, 5'd0, 32'h3), 1'b0);
    feed(mk_item(K_WFI, 32'h8000_0304, 1'b0, 5'd0, 5'd0, 32'h0), 1'b0);
    hold(1, mk_item(K_ADDI, 32'h8000_0308, 1'b0, 5'd9, 5'd0, 32'h4), 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset with two entries queued
    feed(mk_item(K_ADDI, 32'h8000_0400, 1'b0, 5'd10, 5'd0, 32'h5), 1'b0);
    feed(mk_item(K_LUI, 32'h8000_0404, 1'b0, 5'd11, 5'd0, 32'habcde), 1'b0);
    cycle(1'b0, nop, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b1);

    // Random traffic
    have = 1'b0; asserted = 1'b0; pc = 32'h8000_0000;
    for (int i = 0; i < 3000; i++) begin
      if (!have) begin
        r = $urandom_range(0, 11);
        kind = (r < 5) ? K_ADDI : (r < 7) ? K_LUI : (r < 9) ? K_ADD : (r == 9) ? K_MRET :
               (r == 10) ? ($urandom_range(0, 1) ? K_ECALL : K_WFI) : K_ILL;
        pend = mk_item(kind, pc, $urandom_range(0, 11) == 0, 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), $urandom);
        have = 1'b1;
      end
      fv  = asserted || ($urandom_range(0, 9) < 7);
      rdy = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 39) == 0;
      res = ser_m ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      rs  = $urandom_range(0, 499) == 0;
      cycle(fv, pend, rdy, fl, res, rs, acc);
      if (rs || fl) begin
        have = 1'b0; asserted = 1'b0;
        pc = rs ? 32'h8000_0000 : {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      end else if (acc) begin
        have = 1'b0; asserted = 1'b0; pc = pc + 32'd4;
      end else begin
        asserted = fv;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
